uart_cmd_parser: RTL and testbench

- Sits downstream of the uart block's RX FIFO and upstream of its TX FIFO.
- Pops received bytes, assembles fixed 5-byte command frames, and executes register write/read accesses on a simple register port.
- Returns a 1-byte response through the uart TX FIFO.
- Provides the host-to-register control path for the design over the serial link.

---
 rtl/uart_cmd_parser.sv | 119 +++++++++++
 tb/tb_uart_cmd_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Host command parser: pops SYNC/CMD/ADDR/DATA/CHK frames from the uart RX FIFO,
// performs one register write or read, and pushes a one-byte reply to the TX FIFO.
module uart_cmd_parser #(
    parameter int          TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [7:0]  ACK     = 8'h06,
    parameter logic [7:0]  NAK     = 8'h15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       reg_we,
    output logic       reg_re,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RESP
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [7:0]    cmd_q, addr_q, data_q;
    logic          nak_q;
    logic          in_frame, accepting, frame_ok;

    assign in_frame  = (state == S_CMD) || (state == S_ADDR) ||
                       (state == S_DATA) || (state == S_CHK);
    assign accepting = in_frame || (state == S_IDLE);
    // Pop is gated by reset so nothing is consumed while the block is held in reset.
    assign rd_uart   = reset && accepting && !rx_empty;
    assign wr_uart   = (state == S_RESP) && !tx_full;
    assign busy      = (state != S_IDLE);
    assign frame_ok  = ((cmd_q ^ addr_q ^ data_q) == r_data);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            nak_q     <= 1'b0;
            w_data    <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (in_frame && !rd_uart) begin
                // Starved mid-frame: abandon the partial frame after TIMEOUT idle cycles.
                if (tcnt == TLAST) begin
                    state   <= S_IDLE;
                    tcnt    <= '0;
                    err_cnt <= sat_inc(err_cnt);
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                if (rd_uart) tcnt <= '0;
                case (state)
                    S_IDLE:  if (rd_uart && r_data == SYNC) state <= S_CMD;
                    S_CMD:   begin cmd_q  <= r_data; state <= S_ADDR; end
                    S_ADDR:  begin addr_q <= r_data; state <= S_DATA; end
                    S_DATA:  begin data_q <= r_data; state <= S_CHK;  end
                    S_CHK: begin
                        // Strobes are launched here so they are high exactly during EXEC.
                        reg_addr  <= addr_q;
                        reg_wdata <= data_q;
                        reg_we    <= frame_ok && (cmd_q == CMD_WR);
                        reg_re    <= frame_ok && (cmd_q == CMD_RD);
                        nak_q     <= !(frame_ok && (cmd_q == CMD_WR || cmd_q == CMD_RD));
                        state     <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (nak_q) begin
                            w_data  <= NAK;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_RESP;
                        end else if (reg_re) begin
                            state <= S_RDWAIT;
                        end else begin
                            w_data <= ACK;
                            state  <= S_RESP;
                        end
                    end
                    S_RDWAIT: begin
                        w_data <= reg_rdata;
                        state  <= S_RESP;
                    end
                    S_RESP:  if (!tx_full) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser: a FIFO model feeds bytes, a frame-level
// reference model predicts every output each cycle, plus literal directed checks.
module tb_uart_cmd_parser;

    localparam int         TO   = 50;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty, rd_uart, tx_full = 1'b0, wr_uart, reg_we, reg_re, busy;
    logic [7:0] r_data, w_data, reg_addr, reg_wdata, reg_rdata = 8'h00, err_cnt;

    uart_cmd_parser #(.TIMEOUT(TO), .SYNC(SYNC), .ACK(ACK), .NAK(NAK)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO model
    logic [7:0] fifo [0:1023];
    logic [9:0] wp = '0, rp = '0;
    assign rx_empty = (wp == rp);
    assign r_data   = fifo[rp];
    always @(posedge clk or negedge reset)
        if (!reset) rp <= wp;
        else if (rd_uart && wp != rp) rp <= rp + 10'd1;

    int vectors = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position, idle count, and post-frame timeline
    typedef enum int {K_WR, K_RD, K_NAK} kind_t;
    bit         m_acc = 1'b1;
    int         m_pos = 0, m_idle = 0, m_k = 0, m_err = 0;
    logic [7:0] fr [1:4];
    kind_t      m_kind = K_WR;
    logic [7:0] m_resp = 8'h00;

    // Observed-traffic records for the directed literal checks
    int         cyc = 0, push_cnt = 0, we_cnt = 0, re_cnt = 0, push_cyc = 0, we_cyc = 0;
    logic [7:0] last_push = 0, we_addr = 0, we_data = 0, re_addr = 0;

    always @(negedge clk) begin
        bit pop, e_we, e_re, e_wr;
        cyc++;
        if (!reset) begin
            m_acc = 1'b1; m_pos = 0; m_idle = 0; m_k = 0; m_err = 0;
            chk("reset_outputs", {rd_uart, wr_uart, w_data, reg_we, reg_re, reg_addr,
                                  reg_wdata, busy, err_cnt}, 64'd0);
        end else begin
            pop  = m_acc && !rx_empty;
            e_we = !m_acc && m_k == 1 && m_kind == K_WR;
            e_re = !m_acc && m_k == 1 && m_kind == K_RD;
            e_wr = !m_acc && m_k >= (m_kind == K_RD ? 3 : 2) && !tx_full;
            chk("rd_uart", rd_uart, pop);
            chk("busy", busy, !(m_acc && m_pos == 0));
            chk("reg_we", reg_we, e_we);
            chk("reg_re", reg_re, e_re);
            chk("wr_uart", wr_uart, e_wr);
            chk("err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
            if (e_we || e_re) chk("reg_addr", reg_addr, fr[2]);
            if (e_we) chk("reg_wdata", reg_wdata, fr[3]);
            if (e_wr) chk("w_data", w_data, m_resp);

            if (wr_uart) begin push_cnt++; last_push = w_data; push_cyc = cyc; end
            if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; we_cyc = cyc; end
            if (reg_re) begin re_cnt++; re_addr = reg_addr; end

            if (m_acc) begin
                if (pop) begin
                    m_idle = 0;
                    if (m_pos == 0) begin
                        if (r_data == SYNC) m_pos = 1;
                    end else begin
                        fr[m_pos] = r_data;
                        m_pos++;
                    end
                    if (m_pos == 5) begin
                        m_pos = 0; m_acc = 1'b0; m_k = 1;
                        if ((fr[1] ^ fr[2] ^ fr[3]) != fr[4] || !(fr[1] == 8'h01 || fr[1] == 8'h02)) begin
                            m_kind = K_NAK; m_resp = NAK;
                        end else if (fr[1] == 8'h01) begin
                            m_kind = K_WR; m_resp = ACK;
                        end else begin
                            m_kind = K_RD;
                        end
                    end
                end else if (m_pos > 0) begin
                    m_idle++;
                    if (m_idle == TO) begin m_pos = 0; m_idle = 0; m_err++; end
                end
            end else if (e_wr) begin
                m_acc = 1'b1;
            end else begin
                if (m_k == 1 && m_kind == K_NAK) m_err++;
                if (m_k == 2 && m_kind == K_RD) m_resp = reg_rdata;
                m_k++;
            end
        end
    end

    // Random environment noise on tx_full / reg_rdata
    bit rand_en = 1'b0;
    always @(posedge clk) if (rand_en) begin
        #1;
        tx_full   = ($urandom_range(0, 3) == 0);
        reg_rdata = 8'($urandom);
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk); #1;
        fifo[wp] = b;
        wp = wp + 10'd1;
    endtask

    task automatic push_g(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        push(b);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
        push(SYNC); push(c); push(a); push(d); push(k);
    endtask

    task automatic settle();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while ((!rx_empty || busy) && n < 400);
        chk("settle_bound", n < 400, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0;
        logic [7:0] c, a, d, k;
        int r;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Basic write: ACK one cycle after the strobe
        frame(8'h01, 8'h10, 8'h3C, 8'h2D); settle();
        chk("w1_we_cnt", we_cnt, 1);
        chk("w1_addr", we_addr, 8'h10);
        chk("w1_data", we_data, 8'h3C);
        chk("w1_resp", last_push, 8'h06);
        chk("w1_lat", push_cyc - we_cyc, 1);
        chk("w1_err", err_cnt, 0);

        // Read returns reg_rdata
        reg_rdata = 8'h5A;
        frame(8'h02, 8'h20, 8'h00, 8'h22); settle();
        chk("r1_re_cnt", re_cnt, 1);
        chk("r1_addr", re_addr, 8'h20);
        chk("r1_resp", last_push, 8'h5A);
        chk("r1_no_we", we_cnt, 1);

        // Bad checksum and unknown command
        frame(8'h01, 8'h10, 8'h3C, 8'h00); settle();
        chk("bad_no_we", we_cnt, 1);
        chk("bad_resp", last_push, 8'h15);
        chk("bad_err", err_cnt, 1);
        frame(8'h07, 8'h00, 8'h00, 8'h07); settle();
        chk("unk_resp", last_push, 8'h15);
        chk("unk_err", err_cnt, 2);

        // Leading junk discarded silently
        p0 = push_cnt;
        push(8'h00); push(8'hFF); frame(8'h01, 8'h01, 8'h01, 8'h01); settle();
        chk("junk_we_addr", we_addr, 8'h01);
        chk("junk_pushes", push_cnt - p0, 1);
        chk("junk_resp", last_push, 8'h06);

        // Timeout mid-frame, then recovery
        p0 = push_cnt;
        push(SYNC); push(8'h01); settle();
        chk("to_err", err_cnt, 3);
        chk("to_no_push", push_cnt, p0);
        frame(8'h01, 8'h33, 8'h44, 8'h76); settle();
        chk("to_next_addr", we_addr, 8'h33);
        chk("to_next_resp", last_push, 8'h06);

        // Backpressure from TX FIFO
        p0 = push_cnt; w0 = we_cnt;
        tx_full = 1'b1;
        frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        repeat (20) @(posedge clk); #1;
        chk("bp_busy", busy, 1);
        chk("bp_no_push", push_cnt, p0);
        chk("bp_we", we_cnt - w0, 1);
        tx_full = 1'b0; settle();
        chk("bp_push", push_cnt - p0, 1);
        chk("bp_resp", last_push, 8'h06);

        // Reset in mid-frame
        p0 = push_cnt;
        push(SYNC); push(8'h01); repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        frame(8'h01, 8'h55, 8'hAA, 8'hFE); settle();
        chk("rst_next_addr", we_addr, 8'h55);
        chk("rst_pushes", push_cnt - p0, 1);
        chk("rst_err", err_cnt, 0);

        // Randomized traffic
        rand_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            a = 8'($urandom); d = 8'($urandom);
            c = (r < 4 || r == 6) ? 8'h01 : (r < 6) ? 8'h02 : 8'($urandom_range(3, 255));
            k = c ^ a ^ d;
            if (r == 6) k = k ^ 8'($urandom_range(1, 255));
            if (r <= 7) begin
                push_g(SYNC); push_g(c); push_g(a); push_g(d); push_g(k);
            end else if (r == 8) begin
                push_g(8'($urandom));
            end else begin
                settle();
                push(SYNC);
                repeat ($urandom_range(0, 3)) push_g(8'($urandom));
                repeat (TO + 5) @(posedge clk);
            end
            if (i % 25 == 0) settle();
        end
        rand_en = 1'b0;
        #1 tx_full = 1'b0;
        repeat (TO + 5) @(posedge clk);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
